// File: rtl/mfi_order_buffer.sv
// Reorder buffer turning out-of-order retirement records into a strictly in-order MFI stream.
// Optional head-record bypass is enabled with `define MFI_ORDER_BYPASS_EN.
module mfi_order_buffer #(
  parameter int          DEPTH       = 8,
  parameter logic [31:0] START_ORDER = 32'd0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [31:0]                in_order,
  input  logic [3:0]                 in_src1_addr,
  input  logic [3:0]                 in_src2_addr,
  input  logic [3:0]                 in_dest_addr,
  output logic                       mfi_valid,
  output logic [31:0]                mfi_order,
  output logic [3:0]                 mfi_src1_addr,
  output logic [3:0]                 mfi_src2_addr,
  output logic [3:0]                 mfi_dest_addr,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       err_stale,
  output logic                       err_dup,
  output logic                       err_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] OCC_ONE = {{AW{1'b0}}, 1'b1};

  logic [DEPTH-1:0] slot_valid_r;
  logic [DEPTH-1:0] slot_valid_s;
  logic [3:0]       slot_src1_r [DEPTH];
  logic [3:0]       slot_src2_r [DEPTH];
  logic [3:0]       slot_dest_r [DEPTH];
  logic [31:0]      next_order_r;

  logic [31:0]   d_s;
  logic [AW-1:0] slot_idx_s;
  logic [AW-1:0] head_idx_s;
  logic          stale_s;
  logic          overflow_s;
  logic          dup_s;
  logic          accept_s;
  logic          bypass_s;
  logic          write_s;
  logic          emit_s;

  // Classify the incoming record and decide write / emit / bypass for this cycle.
  always_comb begin
    d_s          = in_order - next_order_r;
    slot_idx_s   = in_order[AW-1:0];
    head_idx_s   = next_order_r[AW-1:0];
    stale_s      = in_valid && d_s[31];
    overflow_s   = in_valid && !d_s[31] && (d_s >= 32'(DEPTH));
    dup_s        = in_valid && !stale_s && !overflow_s && slot_valid_r[slot_idx_s];
    accept_s     = in_valid && !stale_s && !overflow_s && !dup_s;
    emit_s       = slot_valid_r[head_idx_s];
`ifdef MFI_ORDER_BYPASS_EN
    // An accepted d == 0 record implies an empty head slot, so it can go straight out.
    bypass_s     = accept_s && (d_s == 32'd0);
`else
    bypass_s     = 1'b0;
`endif
    write_s      = accept_s && !bypass_s;
    slot_valid_s = slot_valid_r;
    if (write_s) begin
      slot_valid_s[slot_idx_s] = 1'b1;
    end else begin
      slot_valid_s = slot_valid_s;
    end
    if (emit_s) begin
      slot_valid_s[head_idx_s] = 1'b0;
    end else begin
      slot_valid_s = slot_valid_s;
    end
  end

  // Slot payload storage; only meaningful while the matching valid bit is set.
  always_ff @(posedge clock) begin
    if (write_s && !reset) begin
      slot_src1_r[slot_idx_s] <= in_src1_addr;
      slot_src2_r[slot_idx_s] <= in_src2_addr;
      slot_dest_r[slot_idx_s] <= in_dest_addr;
    end
  end

  // Control state, registered outputs and sticky error flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      slot_valid_r  <= '0;
      next_order_r  <= START_ORDER;
      mfi_valid     <= 1'b0;
      mfi_order     <= 32'd0;
      mfi_src1_addr <= 4'd0;
      mfi_src2_addr <= 4'd0;
      mfi_dest_addr <= 4'd0;
      occupancy     <= '0;
      err_stale     <= 1'b0;
      err_dup       <= 1'b0;
      err_overflow  <= 1'b0;
    end else begin
      slot_valid_r <= slot_valid_s;
      if (emit_s) begin
        mfi_valid     <= 1'b1;
        mfi_order     <= next_order_r;
        mfi_src1_addr <= slot_src1_r[head_idx_s];
        mfi_src2_addr <= slot_src2_r[head_idx_s];
        mfi_dest_addr <= slot_dest_r[head_idx_s];
        next_order_r  <= next_order_r + 32'd1;
      end else if (bypass_s) begin
        mfi_valid     <= 1'b1;
        mfi_order     <= in_order;
        mfi_src1_addr <= in_src1_addr;
        mfi_src2_addr <= in_src2_addr;
        mfi_dest_addr <= in_dest_addr;
        next_order_r  <= next_order_r + 32'd1;
      end else begin
        mfi_valid <= 1'b0;
      end
      case ({write_s, emit_s})
        2'b10:   occupancy <= occupancy + OCC_ONE;
        2'b01:   occupancy <= occupancy - OCC_ONE;
        default: occupancy <= occupancy;
      endcase
      err_stale    <= err_stale    | stale_s;
      err_dup      <= err_dup      | dup_s;
      err_overflow <= err_overflow | overflow_s;
    end
  end

endmodule

// File: tb/tb_mfi_order_buffer.sv
// Scoreboard bench for mfi_order_buffer: directed reorder, error, wrap-around and reset scenarios.
`timescale 1ns/1ps
module tb_mfi_order_buffer;

  typedef struct packed {
    logic [31:0] order;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic [3:0]  dst;
  } rec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        v_main = 1'b0;
  logic        v_wrap = 1'b0;
  logic [31:0] in_order = 32'd0;
  logic [3:0]  in_s1 = 4'd0, in_s2 = 4'd0, in_dst = 4'd0;

  logic        m_valid, w_valid;
  logic [31:0] m_order, w_order;
  logic [3:0]  m_s1, m_s2, m_dst, w_s1, w_s2, w_dst;
  logic [3:0]  m_occ, w_occ;
  logic        m_stale, m_dup, m_ovf, w_stale, w_dup, w_ovf;

  int n_cmp = 0;
  int n_bad = 0;
  rec_t q_main[$];
  rec_t q_wrap[$];

  always #5 clock = ~clock;

  mfi_order_buffer #(.DEPTH(8), .START_ORDER(32'd0)) u_dut (
    .clock(clock), .reset(reset), .in_valid(v_main), .in_order(in_order),
    .in_src1_addr(in_s1), .in_src2_addr(in_s2), .in_dest_addr(in_dst),
    .mfi_valid(m_valid), .mfi_order(m_order), .mfi_src1_addr(m_s1),
    .mfi_src2_addr(m_s2), .mfi_dest_addr(m_dst), .occupancy(m_occ),
    .err_stale(m_stale), .err_dup(m_dup), .err_overflow(m_ovf));

  mfi_order_buffer #(.DEPTH(8), .START_ORDER(32'hFFFF_FFFE)) u_wrap (
    .clock(clock), .reset(reset), .in_valid(v_wrap), .in_order(in_order),
    .in_src1_addr(in_s1), .in_src2_addr(in_s2), .in_dest_addr(in_dst),
    .mfi_valid(w_valid), .mfi_order(w_order), .mfi_src1_addr(w_s1),
    .mfi_src2_addr(w_s2), .mfi_dest_addr(w_dst), .occupancy(w_occ),
    .err_stale(w_stale), .err_dup(w_dup), .err_overflow(w_ovf));

  function automatic rec_t mk(input logic [31:0] o);
    rec_t r;
    r.order = o;
    r.s1    = o[3:0];
    r.s2    = ~o[3:0];
    r.dst   = o[3:0] ^ 4'h5;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one record (or idle) for the next rising edge.
  task automatic step(input logic vm, input logic vw, input rec_t r);
    @(negedge clock);
    v_main   = vm;
    v_wrap   = vw;
    in_order = r.order;
    in_s1    = r.s1;
    in_s2    = r.s2;
    in_dst   = r.dst;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, mk(32'd0));
  endtask

  task automatic send(input rec_t r);
    step(1'b1, 1'b0, r);
  endtask

  // Main-instance monitor: every emitted beat must match the scoreboard head.
  always @(negedge clock) begin
    if (!reset && m_valid) begin
      n_cmp++;
      if (q_main.size() == 0) begin
        n_bad++;
        $display("FAIL main_unexpected: got order 0x%08h expected no output", m_order);
      end else begin
        rec_t e;
        e = q_main.pop_front();
        if ({m_order, m_s1, m_s2, m_dst} !== e) begin
          n_bad++;
          $display("FAIL main_beat: got %h/%h/%h/%h expected %h/%h/%h/%h",
                   m_order, m_s1, m_s2, m_dst, e.order, e.s1, e.s2, e.dst);
        end
      end
    end
  end

  // Wrap-instance monitor.
  always @(negedge clock) begin
    if (!reset && w_valid) begin
      n_cmp++;
      if (q_wrap.size() == 0) begin
        n_bad++;
        $display("FAIL wrap_unexpected: got order 0x%08h expected no output", w_order);
      end else begin
        rec_t e;
        e = q_wrap.pop_front();
        if ({w_order, w_s1, w_s2, w_dst} !== e) begin
          n_bad++;
          $display("FAIL wrap_beat: got %h/%h/%h/%h expected %h/%h/%h/%h",
                   w_order, w_s1, w_s2, w_dst, e.order, e.s1, e.s2, e.dst);
        end
      end
    end
  end

  initial begin
    rec_t a, b;
    idle(2);
    reset = 1'b0;
    chk("reset_valid", {31'd0, m_valid}, 32'd0);
    chk("reset_order", m_order, 32'd0);
    chk("reset_fields", {20'd0, m_s1, m_s2, m_dst}, 32'd0);
    chk("reset_occ", {28'd0, m_occ}, 32'd0);
    chk("reset_errs", {29'd0, m_stale, m_dup, m_ovf}, 32'd0);

    // In-order stream 0,1,2
    for (int i = 0; i < 3; i++) q_main.push_back(mk(32'(i)));
    send(mk(32'd0));
    send(mk(32'd1));
`ifdef MFI_ORDER_BYPASS_EN
    chk("inorder_occ_e1", {28'd0, m_occ}, 32'd0);
    chk("inorder_valid_e1", {31'd0, m_valid}, 32'd1);
`else
    chk("inorder_occ_e1", {28'd0, m_occ}, 32'd1);
    chk("inorder_valid_e1", {31'd0, m_valid}, 32'd0);
`endif
    send(mk(32'd2));
    chk("inorder_valid_e2", {31'd0, m_valid}, 32'd1);
    idle(1);
    idle(1);
`ifdef MFI_ORDER_BYPASS_EN
    chk("inorder_valid_e4", {31'd0, m_valid}, 32'd0);
`else
    chk("inorder_valid_e4", {31'd0, m_valid}, 32'd1);
`endif
    idle(2);
    chk("inorder_occ_end", {28'd0, m_occ}, 32'd0);

    // Reverse arrival 6,5,4,3 (next_order = 3)
    for (int i = 3; i < 7; i++) q_main.push_back(mk(32'(i)));
    send(mk(32'd6));
    send(mk(32'd5));
    chk("rev_occ1", {28'd0, m_occ}, 32'd1);
    send(mk(32'd4));
    chk("rev_occ2", {28'd0, m_occ}, 32'd2);
    send(mk(32'd3));
    chk("rev_occ3", {28'd0, m_occ}, 32'd3);
    chk("rev_no_emit", {31'd0, m_valid}, 32'd0);
    idle(1);
`ifdef MFI_ORDER_BYPASS_EN
    chk("rev_occ4", {28'd0, m_occ}, 32'd3);
`else
    chk("rev_occ4", {28'd0, m_occ}, 32'd4);
    chk("rev_still_no_emit", {31'd0, m_valid}, 32'd0);
`endif
    idle(6);
    chk("rev_drained", {28'd0, m_occ}, 32'd0);
    chk("rev_no_errs", {29'd0, m_stale, m_dup, m_ovf}, 32'd0);

    // Stale: order 0 with next_order = 7
    send(mk(32'd0));
    idle(1);
    chk("stale_flag", {31'd0, m_stale}, 32'd1);
    chk("stale_occ", {28'd0, m_occ}, 32'd0);

    // Duplicate order 9: first copy kept
    a = mk(32'd9);
    b = a;
    b.s1 = 4'hA; b.s2 = 4'hB; b.dst = 4'hC;
    q_main.push_back(mk(32'd7));
    q_main.push_back(mk(32'd8));
    q_main.push_back(a);
    send(a);
    send(b);
    idle(1);
    chk("dup_flag", {31'd0, m_dup}, 32'd1);
    chk("dup_occ", {28'd0, m_occ}, 32'd1);
    send(mk(32'd7));
    send(mk(32'd8));
    idle(4);
    chk("dup_drained", {28'd0, m_occ}, 32'd0);

    // Overflow: next_order = 10, order 18 is d = 8, order 17 is d = 7
    send(mk(32'd18));
    idle(1);
    chk("ovf_flag", {31'd0, m_ovf}, 32'd1);
    chk("ovf_occ", {28'd0, m_occ}, 32'd0);
    send(mk(32'd17));
    idle(1);
    chk("ovf_edge_accept", {28'd0, m_occ}, 32'd1);
    for (int i = 10; i < 18; i++) q_main.push_back(mk(32'(i)));
    for (int i = 10; i < 17; i++) send(mk(32'(i)));
    idle(4);
    chk("ovf_drained", {28'd0, m_occ}, 32'd0);

    // Wrap-around on the second instance
    q_wrap.push_back(mk(32'hFFFF_FFFE));
    q_wrap.push_back(mk(32'hFFFF_FFFF));
    q_wrap.push_back(mk(32'h0000_0000));
    step(1'b0, 1'b1, mk(32'hFFFF_FFFF));
    step(1'b0, 1'b1, mk(32'hFFFF_FFFE));
    step(1'b0, 1'b1, mk(32'h0000_0000));
    idle(5);
    chk("wrap_errs", {29'd0, w_stale, w_dup, w_ovf}, 32'd0);
    chk("wrap_occ", {28'd0, w_occ}, 32'd0);

    // Reset mid-operation: 19 and 20 buffered (next_order = 18)
    send(mk(32'd19));
    send(mk(32'd20));
    idle(1);
    chk("pre_reset_occ", {28'd0, m_occ}, 32'd2);
    send(mk(32'd1));
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("midreset_occ", {28'd0, m_occ}, 32'd0);
    chk("midreset_errs", {29'd0, m_stale, m_dup, m_ovf}, 32'd0);
    chk("midreset_valid", {31'd0, m_valid}, 32'd0);
    q_main.push_back(mk(32'd0));
    send(mk(32'd0));
    idle(6);
    chk("post_reset_occ", {28'd0, m_occ}, 32'd0);

    chk("main_queue_empty", 32'(q_main.size()), 32'd0);
    chk("wrap_queue_empty", 32'(q_wrap.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mfi_order_buffer.md
# mfi_order_buffer

Reorders per-instruction retirement records, which arrive tagged with a program-order index in any order, into a strictly in-order MFI stream. It sits directly upstream of the MFI property checkers, including the causal check. Those checkers depend on `mfi_order` incrementing by exactly 1 per valid beat. Protocol violations (stale, duplicate, or out-of-window orders) are flagged on sticky error outputs and the offending record is dropped.

## Interface
- `DEPTH`, default 8: reorder window in records; power of 2, ≥2.
- `START_ORDER`, default 0: first order index expected after reset.
- `clock` input 1: all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: a retirement record is present this cycle. There is no backpressure; the block always accepts.
- `in_order` input 32: program-order index of the record.
- `in_src1_addr`, `in_src2_addr`, `in_dest_addr` input 4 each: register indices.
- `mfi_valid` output 1: in-order record is present on the `mfi_*` outputs.
- `mfi_order` output 32: order index of the emitted record.
- `mfi_src1_addr`, `mfi_src2_addr`, `mfi_dest_addr` output 4 each: register fields of the emitted record.
- `occupancy` output log2(DEPTH)+1: number of buffered records not yet emitted.
- `err_stale`, `err_dup`, `err_overflow` output 1 each: sticky error flags.

## Operation
- **Storage:** DEPTH slots. Each slot holds a valid bit plus the three address fields. The slot index is `in_order[log2(DEPTH)-1:0]`.
- **`next_order` register:** 32-bit index of the next record to emit. It resets to `START_ORDER`.
- **Window offset:** `d = in_order - next_order`, computed mod 2^32, so wrap-around is handled naturally.
- **Input classification** (evaluated only when `in_valid` is high), in priority order:
  - `d[31]` = 1: stale. Set `err_stale` and drop the record.
  - `d ≥ DEPTH`: overflow. Set `err_overflow` and drop the record.
  - Target slot already valid: duplicate. Set `err_dup` and drop the record; the original slot contents are kept.
  - Otherwise: write the fields into the slot and set the slot's valid bit.
- **Emit rule:** each cycle, if the slot at `next_order[log2(DEPTH)-1:0]` is valid:
  - load its fields into the output registers;
  - set `mfi_order` = `next_order` and `mfi_valid` = 1;
  - clear the slot's valid bit and increment `next_order`.
  Otherwise `mfi_valid` = 0 and the other outputs hold their previous values. At most one record is emitted per cycle.
- **Simultaneous accept and emit:** allowed because they target different slots. The emitted slot index differs from the written one, since `d` = 0 is only bypass-eligible (see Configuration).
- **Occupancy:** `occupancy` increments on accept and decrements on emit; it is unchanged when both happen in the same cycle.
- **Error flags:** they stay set until reset.
- **Reset** (including mid-operation): all slot valid bits clear, `next_order` = `START_ORDER`, `mfi_valid` = 0, all `mfi_*` fields = 0, `occupancy` = 0, all error flags = 0. Records buffered before reset are discarded.

## Timing
- All outputs are registered and there are no combinational input-to-output paths.
- **Base latency:** a record accepted at edge N with `d` = 0 is written to its slot at N and emitted (`mfi_valid` high) after edge N+1.
- **Drain rate:** buffered successors drain one per cycle with no gaps.
- **Error timing:** an error flag asserts in the cycle following the offending input edge.
- **Input during reset:** an `in_valid` asserted in the same cycle as `reset` is ignored.

## Configuration
- `MFI_ORDER_BYPASS_EN`: bypass path for the next expected record.
  - Defined: when `in_valid` is high, `d` = 0 and the head slot is empty, the record loads the output registers directly at edge N. It is never written to a slot, `occupancy` is unchanged, and `next_order` increments. Latency is 1 edge (`mfi_valid` high after edge N).
  - Undefined: no bypass; latency is 2 edges as described in Timing.
  - All error rules are identical in both builds.

## Test plan
1. **In-order stream:** orders 0, 1, 2 on consecutive cycles starting at edge 1, no bypass, DEPTH=8 → `mfi_valid` high after edges 2, 3, 4 with `mfi_order` 0, 1, 2; `occupancy` peaks at 1. With bypass: outputs appear one cycle earlier and `occupancy` stays 0.
2. **Reverse arrival:** orders 3, 2, 1, 0 on consecutive cycles → nothing is emitted until order 0 arrives, then orders 0, 1, 2, 3 emit on four back-to-back cycles. `occupancy` goes 1→4 and then drains to 0. Address fields match the inputs for each order.
3. **Stale and duplicate:**
   - After order 0 is emitted, inject order 0 again → `err_stale` = 1 and no output.
   - Inject order 5 twice while `next_order` = 1 → `err_dup` = 1; the first copy's fields are emitted later.
4. **Overflow:** DEPTH=8 and `next_order` = 0; inject order 8 → `err_overflow` = 1 and `occupancy` unchanged. Order 7 is accepted normally.
5. **Wrap-around:** `START_ORDER` = 0xFFFFFFFE; inject orders 0xFFFFFFFF, 0xFFFFFFFE, 0x00000000 → emits 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 with no errors.
6. **Reset mid-operation:** buffer orders 1 and 2, assert reset for 1 cycle → `occupancy` = 0 and errors clear. Then inject order 0 → only order 0 is emitted; the old orders 1 and 2 never appear.
